// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings and sequencer state encoding.
package proc_pkg;

    localparam int unsigned OP_W = 3;
    localparam int unsigned ST_W = 3;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_XNOR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(7);

    typedef enum logic [OP_W-1:0] {
        OPC_LOAD  = OP_LOAD,
        OPC_STORE = OP_STORE,
        OPC_ADD   = OP_ADD,
        OPC_SUB   = OP_SUB,
        OPC_BNE   = OP_BNE,
        OPC_XOR   = OP_XOR,
        OPC_XNOR  = OP_XNOR,
        OPC_HALT  = OP_HALT
    } opcode_t;

    // Encoding 7 is unused and recovers to S0.
    typedef enum logic [ST_W-1:0] {
        S0    = ST_W'(0),
        S1    = ST_W'(1),
        S2    = ST_W'(2),
        S3    = ST_W'(3),
        S4    = ST_W'(4),
        S5    = ST_W'(5),
        SHALT = ST_W'(6)
    } seq_state_t;

endpackage

// File: rtl/sequencer.sv
// Control-path FSM: fetches, decodes and sequences datapath strobes per instruction.
module sequencer
    import proc_pkg::*;
(
    input  logic            clock,
    input  logic            n_reset,
    input  logic            z_flag,
    input  logic [OP_W-1:0] op,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_xor,
    output logic            ALU_xnor,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            load_IR,
    output logic            Addr_bus,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    seq_state_t state;
    seq_state_t next_state;
    opcode_t    opcode;

    assign opcode = opcode_t'(op);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state <= S0;
        else          state <= next_state;
    end

    // Outputs are decoded directly from state/op/z_flag so strobes align with the datapath edge.
    always_comb begin
        next_state = S0;
        ACC_bus    = 1'b0;
        load_ACC   = 1'b0;
        ALU_ACC    = 1'b0;
        ALU_add    = 1'b0;
        ALU_sub    = 1'b0;
        ALU_xor    = 1'b0;
        ALU_xnor   = 1'b0;
        PC_bus     = 1'b0;
        load_PC    = 1'b0;
        INC_PC     = 1'b0;
        load_IR    = 1'b0;
        Addr_bus   = 1'b0;
        load_MAR   = 1'b0;
        MDR_bus    = 1'b0;
        load_MDR   = 1'b0;
        CS         = 1'b0;
        R_NW       = 1'b0;
        halted     = 1'b0;

        case (state)
            S0: begin
                PC_bus     = 1'b1;
                load_MAR   = 1'b1;
                INC_PC     = 1'b1;
                load_PC    = 1'b1;
                next_state = S1;
            end
            S1: begin
                CS         = 1'b1;
                R_NW       = 1'b1;
                next_state = S2;
            end
            S2: begin
                MDR_bus    = 1'b1;
                load_IR    = 1'b1;
                next_state = S3;
            end
            S3: begin
                case (opcode)
                    OPC_BNE: begin
                        Addr_bus   = 1'b1;
                        load_PC    = ~z_flag;
                        next_state = S0;
                    end
                    OPC_HALT: begin
                        next_state = SHALT;
                    end
                    OPC_STORE: begin
                        // Addr_bus feeds only the MAR here, so ACC_bus may share the cycle.
                        Addr_bus   = 1'b1;
                        load_MAR   = 1'b1;
                        ACC_bus    = 1'b1;
                        load_MDR   = 1'b1;
                        next_state = S4;
                    end
                    default: begin
                        Addr_bus   = 1'b1;
                        load_MAR   = 1'b1;
                        next_state = S4;
                    end
                endcase
            end
            S4: begin
                CS = 1'b1;
                if (opcode == OPC_STORE) begin
                    R_NW       = 1'b0;
                    next_state = S0;
                end else begin
                    R_NW       = 1'b1;
                    next_state = S5;
                end
            end
            S5: begin
                MDR_bus  = 1'b1;
                load_ACC = 1'b1;
                ALU_ACC  = (opcode != OPC_LOAD);
                case (opcode)
                    OPC_ADD:  ALU_add  = 1'b1;
                    OPC_SUB:  ALU_sub  = 1'b1;
                    OPC_XOR:  ALU_xor  = 1'b1;
                    OPC_XNOR: ALU_xnor = 1'b1;
                    default: ;
                endcase
                next_state = S0;
            end
            SHALT: begin
                halted     = 1'b1;
                next_state = SHALT;
            end
            default: next_state = S0;
        endcase
    end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer: per-cycle output vectors scored against a spec-table model.
module tb_sequencer;
    import proc_pkg::*;

    localparam int unsigned V_W = 18;

    localparam int B_ACC_BUS  = 0;
    localparam int B_LOAD_ACC = 1;
    localparam int B_ALU_ACC  = 2;
    localparam int B_ALU_ADD  = 3;
    localparam int B_ALU_SUB  = 4;
    localparam int B_ALU_XOR  = 5;
    localparam int B_ALU_XNOR = 6;
    localparam int B_PC_BUS   = 7;
    localparam int B_LOAD_PC  = 8;
    localparam int B_INC_PC   = 9;
    localparam int B_LOAD_IR  = 10;
    localparam int B_ADDR_BUS = 11;
    localparam int B_LOAD_MAR = 12;
    localparam int B_MDR_BUS  = 13;
    localparam int B_LOAD_MDR = 14;
    localparam int B_CS       = 15;
    localparam int B_R_NW     = 16;
    localparam int B_HALTED   = 17;

    typedef struct {
        string            tag;
        logic [V_W-1:0]   vec;
    } exp_t;

    logic            clock;
    logic            n_reset;
    logic            z_flag;
    logic [OP_W-1:0] op;
    logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_xor, ALU_xnor;
    logic PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
    logic MDR_bus, load_MDR, CS, R_NW, halted;
    logic [V_W-1:0] obs;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    sequencer dut (
        .clock    (clock),
        .n_reset  (n_reset),
        .z_flag   (z_flag),
        .op       (op),
        .ACC_bus  (ACC_bus),
        .load_ACC (load_ACC),
        .ALU_ACC  (ALU_ACC),
        .ALU_add  (ALU_add),
        .ALU_sub  (ALU_sub),
        .ALU_xor  (ALU_xor),
        .ALU_xnor (ALU_xnor),
        .PC_bus   (PC_bus),
        .load_PC  (load_PC),
        .INC_PC   (INC_PC),
        .load_IR  (load_IR),
        .Addr_bus (Addr_bus),
        .load_MAR (load_MAR),
        .MDR_bus  (MDR_bus),
        .load_MDR (load_MDR),
        .CS       (CS),
        .R_NW     (R_NW),
        .halted   (halted)
    );

    assign obs = {halted, R_NW, CS, load_MDR, MDR_bus, load_MAR, Addr_bus, load_IR,
                  INC_PC, load_PC, PC_bus, ALU_xnor, ALU_xor, ALU_sub, ALU_add,
                  ALU_ACC, load_ACC, ACC_bus};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected strobes for one state, written from the operation table.
    function automatic logic [V_W-1:0] model(input seq_state_t st, input logic [OP_W-1:0] o,
                                             input logic z);
        logic [V_W-1:0] v;
        v = '0;
        case (st)
            S0: begin
                v[B_PC_BUS] = 1'b1; v[B_LOAD_MAR] = 1'b1;
                v[B_INC_PC] = 1'b1; v[B_LOAD_PC]  = 1'b1;
            end
            S1: begin v[B_CS] = 1'b1; v[B_R_NW] = 1'b1; end
            S2: begin v[B_MDR_BUS] = 1'b1; v[B_LOAD_IR] = 1'b1; end
            S3: begin
                if (o == OP_BNE) begin
                    v[B_ADDR_BUS] = 1'b1; v[B_LOAD_PC] = ~z;
                end else if (o != OP_HALT) begin
                    v[B_ADDR_BUS] = 1'b1; v[B_LOAD_MAR] = 1'b1;
                    if (o == OP_STORE) begin
                        v[B_ACC_BUS] = 1'b1; v[B_LOAD_MDR] = 1'b1;
                    end
                end
            end
            S4: begin v[B_CS] = 1'b1; v[B_R_NW] = (o != OP_STORE); end
            S5: begin
                v[B_MDR_BUS] = 1'b1; v[B_LOAD_ACC] = 1'b1;
                v[B_ALU_ACC] = (o != OP_LOAD);
                v[B_ALU_ADD] = (o == OP_ADD);
                v[B_ALU_SUB] = (o == OP_SUB);
                v[B_ALU_XOR] = (o == OP_XOR);
                v[B_ALU_XNOR] = (o == OP_XNOR);
            end
            SHALT: v[B_HALTED] = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [V_W-1:0] got, input logic [V_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive one instruction starting at a negedge in S0; len cycles are scored, ending at the next S0.
    task automatic run_instr(input string name, input logic [OP_W-1:0] o, input logic z,
                             input int len);
        exp_t e;
        op     = o;
        z_flag = z;
        for (int i = 0; i < len; i++) begin
            e.tag = $sformatf("%s_cyc%0d", name, i);
            e.vec = model(seq_state_t'(ST_W'(i)), o, z);
            sb.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            e = sb.pop_front();
            check(e.tag, obs, e.vec);
            @(negedge clock);
        end
    endtask

    // Sysbus driver exclusivity every cycle while running.
    always @(negedge clock) begin
        if (n_reset) begin
            checks++;
            assert ($onehot0({PC_bus, MDR_bus, ACC_bus})) else begin
                errors++;
                $error("FAIL bus_excl observed=%b expected=onehot0", {PC_bus, MDR_bus, ACC_bus});
            end
        end
    end

    initial begin
        n_reset = 1'b0;
        op      = OP_LOAD;
        z_flag  = 1'b0;
        #3;
        check("reset_async", obs, model(S0, OP_LOAD, 1'b0));
        @(negedge clock);
        check("reset_hold", obs, model(S0, OP_LOAD, 1'b0));
        n_reset = 1'b1;

        run_instr("load",  OP_LOAD,  1'($urandom_range(0, 1)), 6);
        run_instr("add",   OP_ADD,   1'($urandom_range(0, 1)), 6);
        run_instr("sub",   OP_SUB,   1'($urandom_range(0, 1)), 6);
        run_instr("xor",   OP_XOR,   1'($urandom_range(0, 1)), 6);
        run_instr("xnor",  OP_XNOR,  1'($urandom_range(0, 1)), 6);
        run_instr("store", OP_STORE, 1'($urandom_range(0, 1)), 5);
        run_instr("bne_z0", OP_BNE, 1'b0, 4);
        run_instr("bne_z1", OP_BNE, 1'b1, 4);
        run_instr("load2", OP_LOAD, 1'b1, 6);

        // ADD abandoned by a reset pulse in S4.
        run_instr("add_abort", OP_ADD, 1'b0, 4);
        check("add_abort_s4", obs, model(S4, OP_ADD, 1'b0));
        #2 n_reset = 1'b0;
        #1;
        check("add_abort_rst", obs, model(S0, OP_ADD, 1'b0));
        @(negedge clock);
        check("add_abort_noacc", obs, model(S0, OP_ADD, 1'b0));
        n_reset = 1'b1;
        run_instr("after_abort", OP_XOR, 1'b0, 6);

        // HALT then stays put until reset.
        run_instr("halt", OP_HALT, 1'b0, 4);
        for (int i = 0; i < 22; i++) begin
            check($sformatf("halted_%0d", i), obs, model(SHALT, OP_HALT, 1'b0));
            @(negedge clock);
        end
        #3 n_reset = 1'b0;
        #1;
        check("halt_rst_clear", obs, model(S0, OP_HALT, 1'b0));
        @(negedge clock);
        n_reset = 1'b1;
        run_instr("post_halt", OP_ADD, 1'b1, 6);
        run_instr("final_store", OP_STORE, 1'b0, 5);
        check("final_s0", obs, model(S0, OP_LOAD, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequencer.md
# sequencer

Control-path finite state machine for the basic processor. It fetches each instruction over the shared sysbus and decodes the opcode field of the instruction register. It then sequences the register-load, bus-drive and memory strobes, and the accumulator/ALU function selects (`ALU_ACC`, `ALU_add`, `ALU_sub`, `ALU_xor`, `ALU_xnor`, `load_ACC`, `ACC_bus`). It sits directly upstream of the accumulator ALU and consumes that block's `z_flag` for conditional branching.

## Interface
- `OP_W`, 3, opcode width; opcode is the top `OP_W` bits of the instruction register.
- `clock`  in  1  system clock, all state changes on rising edge.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `z_flag`  in  1  accumulator-zero flag from the ALU.
- `op`  in  `OP_W`  opcode field from the instruction register.
- `ACC_bus`, `load_ACC`, `ALU_ACC`, `ALU_add`, `ALU_sub`, `ALU_xor`, `ALU_xnor`  out  1 each  ALU/accumulator controls.
- `PC_bus`, `load_PC`, `INC_PC`  out  1 each  program-counter drive, load, increment.
- `load_IR`, `Addr_bus`  out  1 each  instruction-register load; drive IR address field onto sysbus.
- `load_MAR`, `MDR_bus`, `load_MDR`  out  1 each  memory address/data register controls.
- `CS`, `R_NW`  out  1 each  memory select; 1 = read, 0 = write.
- `halted`  out  1  processor stopped.

## Operation
- Opcodes: LOAD=000, STORE=001, ADD=010, SUB=011, BNE=100, XOR=101, XNOR=110, HALT=111. All encodings are legal.
- States: S0..S5, SHALT. Outputs are combinational from state, `op` and `z_flag`. Any output not listed for a state is 0.
- S0 (fetch addr): `PC_bus`, `load_MAR`, `INC_PC`, `load_PC` = 1. Next state is S1.
- S1 (fetch read): `CS`=1, `R_NW`=1. Next state is S2.
- S2 (IR load): `MDR_bus`, `load_IR` = 1. Next state is S3.
- S3 (decode):
  - BNE: `Addr_bus`=1, `load_PC`=~`z_flag`. Next state is S0.
  - HALT: next state is SHALT.
  - STORE: `Addr_bus`, `load_MAR`, `ACC_bus`, `load_MDR` = 1. Next state is S4.
  - All other opcodes: `Addr_bus`, `load_MAR` = 1. Next state is S4.
- S4 (operand):
  - STORE: `CS`=1, `R_NW`=0. Next state is S0.
  - All other opcodes: `CS`=1, `R_NW`=1. Next state is S5.
- S5 (execute): `MDR_bus`=1, `load_ACC`=1, and `ALU_ACC`=1 unless LOAD. Exactly one function select is set per opcode: ADD→`ALU_add`, SUB→`ALU_sub`, XOR→`ALU_xor`, XNOR→`ALU_xnor`. Next state is S0.
- SHALT: all control outputs 0, `halted`=1. The FSM stays in SHALT until reset.
- At most one sysbus driver (`ACC_bus`, `PC_bus`, `MDR_bus`, `Addr_bus`) is asserted per cycle. The one exception is S3 STORE, where `ACC_bus` and `Addr_bus` are both asserted; the datapath routes `Addr_bus` to the MAR path only.
- Unreachable state encodings recover to S0 on the next edge.

## Timing
- Instruction length in cycles: LOAD/ADD/SUB/XOR/XNOR 6, STORE 5, BNE 4, HALT 4 then stop.
- `op` is sampled combinationally in S3–S5. The IR is loaded at the end of S2, so `op` is stable from S3 onward.
- `z_flag` is sampled only in S3 of BNE. It reflects the accumulator written by the previous instruction's S5.
- Reset asserted: state becomes S0 immediately, regardless of the clock.
  - Outputs while in reset: `PC_bus`=`load_MAR`=`INC_PC`=`load_PC`=1; all other outputs 0, including `halted`. These loads are harmless while the datapath is also in reset.
- Reset mid-instruction abandons the instruction; only effects already clocked remain. The first fetch starts on the first rising edge after `n_reset` deasserts.
- Reset also exits SHALT.

## Structure
- Shared package `proc_pkg` holds:
  - `opcode_t` enum (the 8 opcodes above, width `OP_W`);
  - `seq_state_t` enum (S0–S5, SHALT);
  - localparams for the opcode encodings, shared with the assembler-side testbench.
- Single module with one `always_ff` state register and one `always_comb` next-state/output block.
- No sub-module; the decode is too small to justify one.

## Test plan
- Reset, then release with `op`=LOAD: state sequence S0,S1,S2,S3,S4,S5,S0. In S5, `load_ACC`=1 and `ALU_ACC`=0.
- ADD, SUB, XOR, XNOR each: in S5, `ALU_ACC`=1 with exactly one of add/sub/xor/xnor set; instruction length is 6 cycles.
- STORE: S3 asserts `ACC_bus`+`load_MDR`; S4 has `CS`=1, `R_NW`=0; the next cycle is S0 (5-cycle instruction).
- BNE with `z_flag`=0: S3 has `load_PC`=1, `Addr_bus`=1. BNE with `z_flag`=1: S3 has `load_PC`=0. Both return to S0 after 4 cycles.
- HALT: after S3, `halted`=1 and all controls 0 for 20+ cycles. Asserting `n_reset`=0 clears `halted` asynchronously.
- Pulse `n_reset` low during S4 of ADD: state becomes S0 immediately and `load_ACC` never asserts for that instruction. Every cycle, assertions check that no two of `PC_bus`/`MDR_bus`/`ACC_bus` are set together.
